spi_slave_gen: RTL and testbench

//  Parametrised SPI slave front-end; next generation of the fixed 10-bit slave.
//  - Deserialises {cmd[1:0], payload[DATA_W-1:0]} from MOSI, MSB first, one bit per clk while SS_n is low.
//  - Serialises DATA_W-bit read data onto MISO.
//  - Adds a one-cycle rx_valid pulse, abort detection, an error flag and a busy output.
//  - Sits between the SPI pins and the RAM/register-file controller in the SPI wrapper.

---
 rtl/spi_gen_pkg.sv | 24 ++
 rtl/spi_gen_piso.sv | 65 ++++++
 rtl/spi_slave_gen.sv | 196 +++++++++++++++++++
 tb/tb_spi_slave_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_gen_pkg.sv
// Shared types and constants for the parametrised SPI slave.
package spi_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StRead,
        StWaitTx,
        StSend,
        StDone
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Wide enough to hold DATA_W+2 (longest count including a parity slot).
    function automatic int unsigned cnt_w(input int unsigned data_w);
        return $clog2(data_w + 3);
    endfunction

endpackage

// File: rtl/spi_gen_piso.sv
// MISO serialiser: loads read data, shifts it out MSB first, then returns to the idle level.
// With SPI_SLAVE_PARITY_EN defined an odd-parity bit follows the LSB.
module spi_gen_piso
    import spi_gen_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter bit          MISO_IDL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              last
);
    localparam int unsigned CW = cnt_w(DATA_W);
`ifdef SPI_SLAVE_PARITY_EN
    localparam int unsigned SW = DATA_W + 1;
`else
    localparam int unsigned SW = DATA_W;
`endif
    // The MSB goes straight to MISO on load, so only the remaining bits are stored.
    localparam int unsigned SHW = SW - 1;

    logic [SHW-1:0] sh_q;
    logic [SHW-1:0] sh_load;
    logic [CW-1:0]  cnt_q;
    logic           miso_q;

`ifdef SPI_SLAVE_PARITY_EN
    assign sh_load = {data[DATA_W-2:0], ~^data};
`else
    assign sh_load = data[DATA_W-2:0];
`endif

    assign last = shift && (cnt_q == CW'(1));
    assign miso = miso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            miso_q <= MISO_IDL;
        end else if (clear) begin
            cnt_q  <= '0;
            miso_q <= MISO_IDL;
        end else if (load) begin
            sh_q   <= sh_load;
            cnt_q  <= CW'(SW);
            miso_q <= data[DATA_W-1];
        end else if (shift) begin
            if (cnt_q == CW'(1)) begin
                cnt_q  <= '0;
                miso_q <= MISO_IDL;
            end else if (cnt_q != '0) begin
                cnt_q  <= cnt_q - CW'(1);
                miso_q <= sh_q[SHW-1];
                sh_q   <= sh_q << 1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front-end: receives {cmd, payload} MSB first and serialises read data on MISO.
// Define SPI_SLAVE_PARITY_EN to add an odd-parity bit on MOSI and MISO.
module spi_slave_gen
    import spi_gen_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter bit          MISO_IDL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
    output logic              frame_err
);
    localparam int unsigned CW = cnt_w(DATA_W);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W+1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              rd_addr_ok_q, rd_addr_ok_d;
    logic              abort, frame_done;
    logic              piso_load, piso_shift, piso_clear, piso_last;
`ifdef SPI_SLAVE_PARITY_EN
    logic              par_ph_q, par_ph_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_addr_ok_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rd_addr_ok_q <= rd_addr_ok_d;
        end
    end

`ifdef SPI_SLAVE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_ph_q <= 1'b0;
        end else begin
            par_ph_q <= par_ph_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        rd_addr_ok_d = rd_addr_ok_q;
        abort        = 1'b0;
        frame_done   = 1'b0;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_clear   = 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
        par_ph_d     = par_ph_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (!SS_n) begin
                    state_d = StChkCmd;
                    cnt_d   = CW'(DATA_W + 1);
                end
            end
            StChkCmd: begin
                if (SS_n) begin
                    abort = 1'b1;
                end else begin
                    rx_data_d[DATA_W+1] = MOSI;
                    cnt_d               = cnt_q - CW'(1);
                    state_d             = MOSI ? StRead : StWrite;
                end
            end
            StWrite, StRead: begin
                if (SS_n) begin
                    abort = 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
                end else if (par_ph_q) begin
                    par_ph_d = 1'b0;
                    if (^{rx_data_q[DATA_W-1:0], MOSI}) begin
                        frame_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StDone;
                    end
`endif
                end else begin
                    rx_data_d[cnt_q] = MOSI;
                    if (cnt_q == '0) begin
`ifdef SPI_SLAVE_PARITY_EN
                        par_ph_d = 1'b1;
`else
                        frame_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            StWaitTx: begin
                if (SS_n) begin
                    abort = 1'b1;
                end else if (tx_valid) begin
                    piso_load = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (SS_n) begin
                    abort = 1'b1;
                end else begin
                    piso_shift = 1'b1;
                    if (piso_last) begin
                        rd_addr_ok_d = 1'b0;
                        state_d      = StDone;
                    end
                end
            end
            StDone: begin
                if (SS_n) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Aborts keep the partial rx_data and the read-address qualifier untouched.
        if (abort) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            piso_clear  = 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
            par_ph_d    = 1'b0;
`endif
        end

        // cmd bits were stored on earlier edges, so rx_data_q already holds them here.
        if (frame_done) begin
            rx_valid_d = 1'b1;
            state_d    = StDone;
            case (rx_data_q[DATA_W+1:DATA_W])
                CMD_RD_ADDR: rd_addr_ok_d = 1'b1;
                CMD_RD_DATA: begin
                    if (rd_addr_ok_q) begin
                        state_d = StWaitTx;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                CMD_WR_ADDR, CMD_WR_DATA: ;
                default: ;
            endcase
        end
    end

    spi_gen_piso #(
        .DATA_W   (DATA_W),
        .MISO_IDL (MISO_IDL)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .shift (piso_shift),
        .clear (piso_clear),
        .data  (tx_data),
        .miso  (MISO),
        .last  (piso_last)
    );

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen: directed steps followed by randomized frames
// checked against a frame-level reference model.
module tb_spi_slave_gen;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N      = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [N-1:0]      rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              frame_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          model_ok;
    logic [N-1:0] model_rx;

    always #5 clk = ~clk;

    spi_slave_gen #(
        .DATA_W   (DATA_W),
        .MISO_IDL (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // MOSI bit stream for one frame, MSB first, good parity when parity is enabled.
    function automatic logic [N:0] mk_bits(input logic [1:0] cmd, input logic [DATA_W-1:0] pl);
`ifdef SPI_SLAVE_PARITY_EN
        return {cmd, pl, ~^pl};
`else
        return {1'b0, cmd, pl};
`endif
    endfunction

    // Called at a negedge with the slave idle; returns at the negedge after E0.
    task automatic frame_start();
        SS_n     = 1'b0;
        MOSI     = 1'($urandom);
        tx_valid = 1'($urandom);
        @(negedge clk);
        chk1("busy_start", busy, 1'b1);
    endtask

    task automatic shift_bits(input logic [N:0] bits, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            MOSI     = bits[i];
            tx_valid = 1'($urandom);
            @(negedge clk);
            if (i != 0) begin
                chk1("rx_valid_mid", rx_valid, 1'b0);
                chk1("frame_err_mid", frame_err, 1'b0);
            end
        end
    endtask

    // Caller raises SS_n at a negedge; the next edge must abort.
    task automatic abort_check();
        @(negedge clk);
        chk1("abort_err", frame_err, 1'b1);
        chk1("abort_valid", rx_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_miso", MISO, 1'b0);
        @(negedge clk);
        chk1("abort_err_pulse", frame_err, 1'b0);
    endtask

    task automatic abort_frame(input logic [1:0] cmd, input logic [DATA_W-1:0] pl, input int k);
        logic [N:0] bits;
        bits = mk_bits(cmd, pl);
        frame_start();
        shift_bits(bits >> (NB - k), k);
        SS_n = 1'b1;
        abort_check();
    endtask

    task automatic do_send(input logic [DATA_W-1:0] d, input int wait_cyc, input int abort_at,
                           output bit aborted);
        aborted = 1'b0;
        repeat (wait_cyc) begin
            tx_valid = 1'b0;
            tx_data  = DATA_W'($urandom);
            @(negedge clk);
            chk1("miso_wait", MISO, 1'b0);
            chk1("busy_wait", busy, 1'b1);
        end
        if (abort_at == 0) begin
            SS_n = 1'b1;
            abort_check();
            aborted = 1'b1;
            return;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'($urandom);
        tx_data  = DATA_W'($urandom);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            chk1("miso_bit", MISO, d[i]);
            if (abort_at == int'(DATA_W) - i) begin
                SS_n = 1'b1;
                abort_check();
                aborted = 1'b1;
                return;
            end
            @(negedge clk);
        end
`ifdef SPI_SLAVE_PARITY_EN
        chk1("miso_par", MISO, ~^d);
        @(negedge clk);
`endif
        chk1("miso_idle", MISO, 1'b0);
        model_ok = 1'b0;
    endtask

    task automatic do_frame(input logic [1:0] cmd, input logic [DATA_W-1:0] pl, input bit bad_par,
                            input logic [DATA_W-1:0] txd, input int wait_cyc, input int abort_at);
        logic [N:0] bits;
        bit good, send, aborted;
        bits = mk_bits(cmd, pl);
`ifdef SPI_SLAVE_PARITY_EN
        bits[0] = bits[0] ^ bad_par;
`endif
        frame_start();
        shift_bits(bits, NB);
        good     = !bad_par;
        send     = good && (cmd == 2'b11) && model_ok;
        tx_valid = 1'b0;
        chk1("rx_valid", rx_valid, good);
        chk1("frame_err", frame_err, !good || (cmd == 2'b11 && !model_ok));
        if (good) begin
            chkv("rx_data", rx_data, {cmd, pl});
            model_rx = {cmd, pl};
            if (cmd == 2'b10) model_ok = 1'b1;
        end
        @(negedge clk);
        chk1("rx_valid_pulse", rx_valid, 1'b0);
        chk1("frame_err_pulse", frame_err, 1'b0);
        chk1("busy_frame", busy, 1'b1);
        aborted = 1'b0;
        if (send) do_send(txd, wait_cyc, abort_at, aborted);
        if (!aborted) begin
            repeat ($urandom_range(0, 3)) begin
                MOSI = 1'($urandom);
                @(negedge clk);
                chk1("miso_done", MISO, 1'b0);
                if (good) chkv("rx_hold", rx_data, model_rx);
            end
            SS_n = 1'b1;
            @(negedge clk);
            chk1("busy_end", busy, 1'b0);
            chk1("frame_err_end", frame_err, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        model_ok = 1'b0;
        model_rx = '0;
        #1 rst_n = 1'b0;
        #1;
        chkv("rst_rx_data", rx_data, '0);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_miso", MISO, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Read data without a read address: error pulse, no MISO phase.
        do_frame(2'b11, 8'h3C, 1'b0, 8'h00, 0, -1);
        // Write address.
        do_frame(2'b00, 8'hA5, 1'b0, 8'h00, 0, -1);
        // Read address then read data returning C3 after three idle clocks.
        do_frame(2'b10, 8'h03, 1'b0, 8'h00, 0, -1);
        do_frame(2'b11, 8'h77, 1'b0, 8'hC3, 3, -1);
        // Abort after five bits of write data.
        abort_frame(2'b01, 8'h96, 5);
        // Abort while waiting for read data leaves the read address armed.
        do_frame(2'b10, 8'h40, 1'b0, 8'h00, 0, -1);
        do_frame(2'b11, 8'h41, 1'b0, 8'h5A, 2, 0);
        do_frame(2'b11, 8'h42, 1'b0, 8'hA6, 1, -1);
`ifdef SPI_SLAVE_PARITY_EN
        do_frame(2'b01, 8'hF0, 1'b1, 8'h00, 0, -1);
        do_frame(2'b01, 8'hF0, 1'b0, 8'h00, 0, -1);
`endif

        // Asynchronous reset in the middle of the MISO phase.
        do_frame(2'b10, 8'h11, 1'b0, 8'h00, 0, -1);
        frame_start();
        shift_bits(mk_bits(2'b11, 8'h22), NB);
        chk1("rx_valid_rd", rx_valid, 1'b1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        chk1("miso_pre_rst", MISO, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("midrst_miso", MISO, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_rx_valid", rx_valid, 1'b0);
        chk1("midrst_frame_err", frame_err, 1'b0);
        chkv("midrst_rx_data", rx_data, '0);
        model_ok = 1'b0;
        model_rx = '0;
        SS_n     = 1'b1;
        @(negedge clk);
        // Release reset together with SS_n falling.
        rst_n = 1'b1;
        do_frame(2'b01, 8'h5A, 1'b0, 8'h00, 0, -1);

        for (int it = 0; it < 60; it++) begin
            int op, ab;
            logic [1:0] cmd;
            logic [DATA_W-1:0] pl;
            bit bad;
            op  = int'($urandom_range(0, 9));
            cmd = 2'($urandom);
            pl  = DATA_W'($urandom);
            bad = 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
            bad = ($urandom_range(0, 4) == 0);
`endif
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DATA_W)) : -1;
            if (op < 2) begin
                abort_frame(cmd, pl, int'($urandom_range(0, NB - 1)));
            end else begin
                do_frame(cmd, pl, bad, DATA_W'($urandom), int'($urandom_range(0, 3)), ab);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
